logits_argmax: RTL and testbench
================================

LOGITS_ARGMAX -- requirements
Module: logits_argmax

Interface
REQ-001 Parameter OUT_DIM, default 10, number of int32 logits to scan; SHALL be >= 2.
REQ-002 Parameter LOGIT_W, default 32, logit width (signed).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a scan; sampled only in IDLE.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 y_re  output  1  logit memory read enable.
REQ-008 y_addr  output  $clog2(OUT_DIM)  logit memory read address.
REQ-009 y_data  input  LOGIT_W signed  logit read data, valid exactly 1 cycle after y_re.
REQ-010 out_valid  output  1  result available; held until accepted.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 class_idx  output  $clog2(OUT_DIM)  predicted class (argmax).
REQ-013 best_logit  output  LOGIT_W signed  maximum logit.
REQ-014 margin  output  LOGIT_W+1 unsigned  best_logit minus second-best logit.
REQ-015 done  output  1  one-cycle pulse after the result handshake.

Function
REQ-016 FSM states: IDLE, SCAN, DRAIN, RESULT, DONE; any undefined encoding SHALL return to IDLE.
REQ-017 IDLE: start=1 -> SCAN next cycle with read index k=0; start in any other state SHALL be ignored.
REQ-018 SCAN: y_re=1, y_addr=k for one cycle per index, k=0..OUT_DIM-1 in consecutive cycles; after k=OUT_DIM-1 -> DRAIN.
REQ-019 DRAIN: y_re=0 for one cycle, consuming the final y_data; -> RESULT.
REQ-020 Each y_data word SHALL be compared in the cycle it is valid (one cycle after its y_re).
REQ-021 Index 0 initialises best=y_data, best_idx=0, second=-2^(LOGIT_W-1).
REQ-022 Index k>0: if y_data > best (strict, signed): second<=best, best<=y_data, best_idx<=k; else if y_data > second: second<=y_data.
REQ-023 Ties SHALL resolve to the lowest index; a logit equal to best SHALL set second to that value (margin 0).
REQ-024 margin SHALL be computed in LOGIT_W+1 bits without overflow or saturation.
REQ-025 Latency: start sampled at edge T -> out_valid high from cycle T+OUT_DIM+2 (12 cycles for OUT_DIM=10).
REQ-026 RESULT: out_valid=1; class_idx, best_logit, margin stable while out_valid=1 and out_ready=0.
REQ-027 out_valid=1 and out_ready=1 at an edge -> DONE; out_valid drops in the next cycle.
REQ-028 DONE: done=1 for exactly one cycle, -> IDLE; result outputs hold their values until the next scan's RESULT.
REQ-029 out_ready SHALL have no effect outside RESULT.
REQ-030 Back-to-back: start sampled in the IDLE cycle immediately after DONE SHALL be accepted.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and set busy, y_re, out_valid and done to 0 and y_addr, class_idx, best_logit and margin to 0.
REQ-032 Reset mid-scan or in RESULT SHALL abandon the scan with no out_valid or done pulse; after release, the block SHALL wait for a new start.
REQ-033 After reset release, no output SHALL change until start is sampled.

Structure
REQ-034 Shared package mnist_pkg SHALL hold OUT_DIM (10), LOGIT_W (32) and CLASS_W=$clog2(OUT_DIM), shared with the layer that writes the logits.
REQ-035 One sub-module, top2_tracker, SHALL hold the best/second/best_idx registers and the compare/update rule (REQ-021..023); the FSM and handshake SHALL stay in logits_argmax.

Verification
REQ-036 Logits {5,-3,100,7,0,2,-50,99,1,4}, out_ready=1 -> class_idx=2, best_logit=100, margin=1; out_valid 12 cycles after start; done 1 cycle later.
REQ-037 All logits -7 -> class_idx=0, best_logit=-7, margin=0.
REQ-038 Logit 0 = -2^31, logit 9 = 2^31-1, others 0 -> class_idx=9, margin=2^31-1; then logit 0 = 2^31-1, logit 1 = -2^31, others -2^31 -> margin=2^32-1 (no overflow).
REQ-039 out_ready held 0 for 20 cycles in RESULT -> out_valid and outputs stable; start pulses during RESULT ignored; done only after out_ready rises.
REQ-040 rst_n pulsed low at SCAN index 4 -> busy=0 and out_valid=0 immediately, no done; a new start with fresh logits returns the correct argmax.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared constants and types for the classifier output stage.
// Holds the logit vector geometry used by both the layer that writes the
// logits and the argmax block that reads them back.
package mnist_pkg;

  // Number of output classes (one logit per class).
  localparam int OUT_DIM = 10;

  // Width of one signed logit word.
  localparam int LOGIT_W = 32;

  // Width of a class index / logit memory address.
  localparam int CLASS_W = $clog2(OUT_DIM);

  // Argmax controller states. Any encoding outside this set is illegal and
  // is steered back to IDLE by the controller.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    DRAIN  = 3'd2,
    RESULT = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Most negative value representable in a w-bit two's complement word.
  function automatic logic [63:0] min_signed(input int w);
    logic [63:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/top2_tracker.sv
// Purpose: tracks the largest and second-largest signed logit and the index of the largest.
// Latency: registers update on the edge that ends the cycle a word is valid; next-state is exposed combinationally.
// Backpressure: none; consumes one word per cycle whenever vld_i is high.
module top2_tracker
  import mnist_pkg::*;
#(
  parameter int LOGIT_W = mnist_pkg::LOGIT_W,
  parameter int IDX_W   = mnist_pkg::CLASS_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      vld_i,
  input  logic                      first_i,
  input  logic [IDX_W-1:0]          idx_i,
  input  logic signed [LOGIT_W-1:0] data_i,
  output logic signed [LOGIT_W-1:0] best_nxt_o,
  output logic signed [LOGIT_W-1:0] second_nxt_o,
  output logic [IDX_W-1:0]          idx_nxt_o
);

  // Floor value for "second": any real logit is >= this.
  localparam logic signed [LOGIT_W-1:0] MIN_LOGIT = LOGIT_W'(min_signed(LOGIT_W));

  logic signed [LOGIT_W-1:0] best_q, best_d;
  logic signed [LOGIT_W-1:0] second_q, second_d;
  logic [IDX_W-1:0]          idx_q, idx_d;

  // Compare/update rule: strict greater-than keeps the lowest index on ties,
  // and a word equal to best still lands in second so the margin reads 0.
  always_comb begin
    best_d   = best_q;
    second_d = second_q;
    idx_d    = idx_q;
    if (vld_i) begin
      if (first_i) begin
        best_d   = data_i;
        second_d = MIN_LOGIT;
        idx_d    = '0;
      end else if (data_i > best_q) begin
        second_d = best_q;
        best_d   = data_i;
        idx_d    = idx_i;
      end else if (data_i > second_q) begin
        second_d = data_i;
      end
    end
  end

  // Tracker registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q   <= '0;
      second_q <= MIN_LOGIT;
      idx_q    <= '0;
    end else begin
      best_q   <= best_d;
      second_q <= second_d;
      idx_q    <= idx_d;
    end
  end

  // Next-state view lets the controller capture the final result on the
  // same edge that absorbs the last logit.
  assign best_nxt_o   = best_d;
  assign second_nxt_o = second_d;
  assign idx_nxt_o    = idx_d;

endmodule

// File: rtl/logits_argmax.sv
// Purpose: scans OUT_DIM logits from a 1-cycle-latency memory and reports argmax, max and top-2 margin.
// Latency: start sampled at edge T gives out_valid in cycle T+OUT_DIM+2; done pulses one cycle after handshake.
// Backpressure: result and out_valid hold in RESULT until out_ready; start is ignored while busy.
module logits_argmax
  import mnist_pkg::*;
#(
  parameter int OUT_DIM = mnist_pkg::OUT_DIM,
  parameter int LOGIT_W = mnist_pkg::LOGIT_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  output logic                               busy,
  output logic                               y_re,
  output logic [$clog2(OUT_DIM)-1:0]         y_addr,
  input  logic signed [LOGIT_W-1:0]          y_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(OUT_DIM)-1:0]         class_idx,
  output logic signed [LOGIT_W-1:0]          best_logit,
  output logic [LOGIT_W:0]                   margin,
  output logic                               done
);

  localparam int AW = $clog2(OUT_DIM);
  localparam logic [AW-1:0] LAST_IDX = AW'(OUT_DIM - 1);

  state_e state_q, state_d;
  logic [AW-1:0] k_q, k_d;

  // Read-return tracking: y_data is valid one cycle after y_re.
  logic          rd_vld_q;
  logic [AW-1:0] rd_idx_q;

  // Tracker next-state values.
  logic signed [LOGIT_W-1:0] best_nxt;
  logic signed [LOGIT_W-1:0] second_nxt;
  logic [AW-1:0]             idx_nxt;

  // Held result registers (survive until the next scan's RESULT).
  logic [AW-1:0]             class_q;
  logic signed [LOGIT_W-1:0] best_q;
  logic [LOGIT_W:0]          margin_q;
  logic [LOGIT_W:0]          margin_d;

  top2_tracker #(
    .LOGIT_W (LOGIT_W),
    .IDX_W   (AW)
  ) u_top2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld_i        (rd_vld_q),
    .first_i      (rd_idx_q == '0),
    .idx_i        (rd_idx_q),
    .data_i       (y_data),
    .best_nxt_o   (best_nxt),
    .second_nxt_o (second_nxt),
    .idx_nxt_o    (idx_nxt)
  );

  // One extra bit holds the full range best-second without wrap: the
  // difference of two sign-extended words is always in [0, 2^LOGIT_W-1].
  always_comb begin
    margin_d = {best_nxt[LOGIT_W-1], best_nxt} - {second_nxt[LOGIT_W-1], second_nxt};
  end

  // Next-state logic: walk k through every address, drain the last read, then handshake.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          k_d     = '0;
        end
      end
      SCAN: begin
        if (k_q == LAST_IDX) begin
          state_d = DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      DRAIN: begin
        state_d = RESULT;
      end
      RESULT: begin
        if (out_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Controller state, read index and read-return pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      rd_vld_q <= (state_q == SCAN);
      rd_idx_q <= k_q;
    end
  end

  // Capture the result as the last logit is absorbed (DRAIN -> RESULT edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class_q  <= '0;
      best_q   <= '0;
      margin_q <= '0;
    end else if (state_q == DRAIN) begin
      class_q  <= idx_nxt;
      best_q   <= best_nxt;
      margin_q <= margin_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign y_re       = (state_q == SCAN);
  assign y_addr     = k_q;
  assign out_valid  = (state_q == RESULT);
  assign done       = (state_q == DONE);
  assign class_idx  = class_q;
  assign best_logit = best_q;
  assign margin     = margin_q;

endmodule

// File: tb/tb_logits_argmax.sv
// Directed bench for logits_argmax: memory model with 1-cycle read latency,
// hand-computed argmax/max/margin expectations, handshake and reset cases.
module tb_logits_argmax;

  localparam int N  = 10;
  localparam int AW = $clog2(N);

  localparam int MAXV = 32'sh7FFF_FFFF;
  localparam int MINV = 32'sh8000_0000;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                busy;
  logic                y_re;
  logic [AW-1:0]       y_addr;
  logic signed [31:0]  y_data;
  logic                out_valid;
  logic                out_ready;
  logic [AW-1:0]       class_idx;
  logic signed [31:0]  best_logit;
  logic [32:0]         margin;
  logic                done;

  logic signed [31:0]  mem [N];

  int checks = 0;
  int errors = 0;

  logits_argmax #(
    .OUT_DIM (N),
    .LOGIT_W (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .y_re       (y_re),
    .y_addr     (y_addr),
    .y_data     (y_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .class_idx  (class_idx),
    .best_logit (best_logit),
    .margin     (margin),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Logit memory: data returned one cycle after the read enable.
  always @(posedge clk) begin
    if (y_re) y_data <= mem[y_addr];
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Raise start for one cycle; it is sampled at the posedge in between.
  task automatic start_scan();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count edges after the start-sampling edge until out_valid is seen.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!out_valid) check("valid_timeout", 0, 1);
  endtask

  // With out_ready already high: DONE follows RESULT, then IDLE.
  task automatic handshake(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done"}, done, 1);
    check({tag, "_vdrop"}, out_valid, 0);
    @(posedge clk);
    #1;
    check({tag, "_done1"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic run_scan(input string tag, input int e_idx, input longint e_best,
                          input longint e_margin, output int edges);
    out_ready = 1'b1;
    start_scan();
    wait_valid(edges);
    check({tag, "_idx"}, class_idx, e_idx);
    check({tag, "_best"}, best_logit, e_best);
    check({tag, "_margin"}, margin, e_margin);
    handshake(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int edges;
    int seen;

    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    y_data    = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;

    // Reset state.
    #12;
    check("rst_busy", busy, 0);
    check("rst_yre", y_re, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_addr", y_addr, 0);
    check("rst_idx", class_idx, 0);
    check("rst_best", best_logit, 0);
    check("rst_margin", margin, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic scan: max 100 at index 2, runner-up 99 -> margin 1.
    // out_valid appears in cycle T+12, i.e. after the 11th edge past T.
    mem = '{5, -3, 100, 7, 0, 2, -50, 99, 1, 4};
    run_scan("basic", 2, 100, 1, edges);
    check("latency_edges", edges, N + 1);

    // Back-to-back: start in the IDLE cycle right after DONE; all equal.
    mem = '{-7, -7, -7, -7, -7, -7, -7, -7, -7, -7};
    run_scan("equal", 0, -7, 0, edges);

    // Extremes: max at last index, margin 2^31-1.
    mem = '{MINV, 0, 0, 0, 0, 0, 0, 0, 0, MAXV};
    run_scan("maxlast", 9, MAXV, 64'd2147483647, edges);

    // Full-range margin 2^32-1 with no overflow.
    mem = '{MAXV, MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV};
    run_scan("fullrng", 0, MAXV, 64'd4294967295, edges);

    // Backpressure: tie 8/8 resolves to lowest index, margin 0; hold 20 cycles
    // with start pulses that must be ignored.
    mem = '{3, 8, 8, 1, 0, 0, 0, 0, 0, 0};
    out_ready = 1'b0;
    start_scan();
    wait_valid(edges);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = (i % 3 == 0);
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_done", done, 0);
      check("hold_idx", class_idx, 1);
      check("hold_best", best_logit, 8);
      check("hold_margin", margin, 0);
    end
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_done", done, 1);
    check("bp_vdrop", out_valid, 0);
    @(negedge clk);
    out_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (busy || done || out_valid) seen++;
    end
    check("bp_no_restart", seen, 0);
    check("bp_keep_idx", class_idx, 1);
    check("bp_keep_best", best_logit, 8);

    // Reset at scan index 4: abandon, stay idle, then rescan fresh logits.
    mem = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    out_ready = 1'b1;
    start_scan();
    edges = 0;
    while (!(y_re && y_addr == 4) && edges < 30) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("rst_reach_k4", (y_re && y_addr == 4), 1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_valid", out_valid, 0);
    check("mid_yre", y_re, 0);
    check("mid_idx", class_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (busy || done || out_valid || y_re) seen++;
    end
    check("post_rst_quiet", seen, 0);
    mem = '{10, 20, 30, 40, 50, 60, 70, 80, 90, -100};
    run_scan("rescan", 8, 90, 10, edges);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
